// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state enumeration.
// Commands are {cs_n,ras_n,cas_n,we_n}.
package sdram_pkg;

   localparam logic [3:0] SD_NOP       = 4'b0111;
   localparam logic [3:0] SD_PRECHARGE = 4'b0010;
   localparam logic [3:0] SD_AREF      = 4'b0001;
   localparam logic [3:0] SD_ACTIVE    = 4'b0011;
   localparam logic [3:0] SD_WRITE     = 4'b0100;
   localparam logic [3:0] SD_READ      = 4'b0101;
   localparam logic [3:0] SD_MRS       = 4'b0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARBIT = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } arb_state_t;

   localparam logic LG_WR = 1'b0;
   localparam logic LG_RD = 1'b1;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: refresh has priority, write/read alternate on tie,
// and the owner keeps the command bus until it signals its end.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter logic [3:0] CMD_NOP = 4'b0111,
   parameter int         ADDR_W  = 13
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              init_done,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              ref_req,
   input  logic              ref_end,
   input  logic [3:0]        ref_cmd,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wr_bank,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_bank,
   output logic              ref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic [3:0]        sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [1:0]        sdram_bank,
   output logic              busy
);

   arb_state_t state_q, state_d;
   logic       last_q, last_d;
   logic       ref_en_q, ref_en_d;
   logic       wr_en_q, wr_en_d;
   logic       rd_en_q, rd_en_d;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q  <= IDLE;
         last_q   <= LG_RD;
         ref_en_q <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         ref_en_q <= ref_en_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE:  if (init_done) state_d = ARBIT;
         ARBIT: begin
            if (ref_req) begin
               state_d = AREF;
            end else if (wr_req && rd_req) begin
               state_d = (last_q == LG_RD) ? WRITE : READ;
               last_d  = ~last_q;
            end else if (wr_req) begin
               state_d = WRITE;
               last_d  = LG_WR;
            end else if (rd_req) begin
               state_d = READ;
               last_d  = LG_RD;
            end
         end
         AREF:  if (ref_end) state_d = ARBIT;
         WRITE: if (wr_end)  state_d = ARBIT;
         READ:  if (rd_end)  state_d = ARBIT;
         default: state_d = IDLE;
      endcase
   end

   // Grants pulse only on the ARBIT -> owner transition.
   always_comb begin
      ref_en_d = (state_q == ARBIT) && (state_d == AREF);
      wr_en_d  = (state_q == ARBIT) && (state_d == WRITE);
      rd_en_d  = (state_q == ARBIT) && (state_d == READ);
   end

   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_bank = 2'b00;
      case (state_q)
         IDLE: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         AREF: begin
            sdram_cmd  = ref_cmd;
            sdram_addr = ref_addr;
         end
         WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_bank = wr_bank;
         end
         READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank;
         end
         default: ;
      endcase
   end

   assign ref_en = ref_en_q;
   assign wr_en  = wr_en_q;
   assign rd_en  = rd_en_q;
   assign busy   = (state_q != ARBIT);

endmodule
